// File: rtl/slt_16b_pkg.sv
// Shared ALU definitions used by the set-less-than unit: data width, word type
// and the two legal SLT result encodings.
package slt_16b_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t SLT_TRUE  = 16'h0001;
  localparam word_t SLT_FALSE = 16'h0000;

  // Map the single-bit compare outcome onto a full ALU result word.
  function automatic word_t slt_word(input logic lt);
    word_t res;
    if (lt) begin
      res = SLT_TRUE;
    end else begin
      res = SLT_FALSE;
    end
    return res;
  endfunction

endpackage

// File: rtl/slt_16b_full_adder_1b.sv
// One-bit full adder cell; sixteen of these form the ripple subtractor.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/slt_16b.sv
// Registered 16-bit signed set-less-than: A - B via a ripple chain, with the
// sign of the difference corrected by the overflow flag.
module slt_16b
  import slt_16b_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  logic [WIDTH-1:0] b_inv_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH:0]   carry_s;
  logic             carry_into_msb_s;
  logic             carry_out_msb_s;
  logic             ovf_s;
  logic             lt_s;
  logic [WIDTH-1:0] out_r;
  logic             overflow_r;

  assign b_inv_s    = ~B;
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1b u_fa (
      .a    (A[i]),
      .b    (b_inv_s[i]),
      .cin  (carry_s[i]),
      .sum  (diff_s[i]),
      .cout (carry_s[i+1])
    );
  end

  assign carry_into_msb_s = carry_s[WIDTH-1];
  assign carry_out_msb_s  = carry_s[WIDTH];

  // Overflow flips the sign of the raw difference, so fold it into the compare.
  always_comb begin
    ovf_s = carry_into_msb_s ^ carry_out_msb_s;
    lt_s  = diff_s[WIDTH-1] ^ ovf_s;
  end

  // Result registers; reset clears both without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r      <= SLT_FALSE;
      overflow_r <= 1'b0;
    end else begin
      out_r      <= slt_word(lt_s);
      overflow_r <= ovf_s;
    end
  end

  assign out      = out_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_slt_16b.sv
// Self-checking bench for slt_16b: directed vector table, scoreboard-checked
// random streaming, and asynchronous reset at start-up and mid-stream.
module tb_slt_16b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] out;
  logic        overflow;

  always #5 clk = ~clk;

  slt_16b #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .out      (out),
    .overflow (overflow)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic        ev;
  } vec_t;

  typedef struct {
    logic [15:0] eo;
    logic        ev;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] d;
    d    = a - b;
    e.ev = (a[15] != b[15]) && (d[15] != a[15]);
    e.eo = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
    return e;
  endfunction

  task automatic check(input string nm, input logic [15:0] eo, input logic ev);
    total++;
    if (out === eo && overflow === ev) begin
      passed++;
    end else begin
      $display("FAIL %s: got out=%h overflow=%b, expected out=%h overflow=%b",
               nm, out, overflow, eo, ev);
    end
  endtask

  task automatic check_pop(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got out=%h overflow=%b", nm, out, overflow);
    end else begin
      e = sbq.pop_front();
      check(nm, e.eo, e.ev);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    exp_t        last;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{16'h0004, 16'h0002, 16'h0000, 1'b0};
    vecs[2]  = '{16'h0002, 16'h0004, 16'h0001, 1'b0};
    vecs[3]  = '{16'hFFFC, 16'hFFFE, 16'h0001, 1'b0};
    vecs[4]  = '{16'hFFFE, 16'hFFFC, 16'h0000, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0001, 16'h0001, 1'b1};
    vecs[8]  = '{16'h7FFF, 16'hFFFF, 16'h0000, 1'b1};
    vecs[9]  = '{16'h0001, 16'h8000, 16'h0000, 1'b1};
    vecs[10] = '{16'hFFFF, 16'h0000, 16'h0001, 1'b0};
    vecs[11] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b1};

    // Start-up reset with operands that would otherwise produce 1/1.
    rst_n = 1'b0;
    A     = 16'h8000;
    B     = 16'h0001;
    #2;
    check("reset_async", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      A = vecs[i].a;
      B = vecs[i].b;
      @(posedge clk); #1;
      check($sformatf("vec%0d_%h_%h", i, vecs[i].a, vecs[i].b), vecs[i].eo, vecs[i].ev);
    end

    // Back-to-back streaming; output must hold the previous result until the edge.
    last = '{16'h0001, 1'b1};
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 6 == 0) rb = ra;
      if (i % 6 == 1) rb = ra ^ 16'h8000;
      A = ra;
      B = rb;
      sbq.push_back(model(ra, rb));
      #1;
      check($sformatf("stream%0d_hold", i), last.eo, last.ev);
      @(posedge clk); #1;
      last = sbq[0];
      check_pop($sformatf("stream%0d_%h_%h", i, ra, rb));
    end

    // Mid-stream reset: load a nonzero result, then drop rst_n between edges.
    A = 16'h8000;
    B = 16'h0001;
    sbq.push_back(model(A, B));
    @(posedge clk); #1;
    check_pop("pre_reset");
    A = 16'h0002;
    B = 16'h0004;
    sbq.push_back(model(A, B));
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_async", 16'h0000, 1'b0);
    sbq.delete();
    @(posedge clk); #1;
    check("midreset_hold", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h0002;
    B = 16'h0004;
    sbq.push_back(model(A, B));
    #1;
    check("post_release_before_edge", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check_pop("post_release_first");
    A = 16'h7FFF;
    B = 16'hFFFF;
    sbq.push_back(model(A, B));
    @(posedge clk); #1;
    check_pop("post_release_second");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/slt_16b.md
# slt_16b

Registered 16-bit signed set-less-than unit for the ALU datapath. Each cycle it compares two two's-complement operands by computing A − B. It drives a 16-bit result equal to 1 when A < B (signed) and 0 otherwise, plus the signed-overflow flag of that subtraction. It sits beside the ALU's add, sub and logic units and feeds the ALU result mux.

## Interface
Parameters:
- WIDTH, 16: operand and result width. Only 16 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- A  input  16  signed two's-complement operand.
- B  input  16  signed two's-complement operand.
- out  output  16  0x0001 if A < B (signed), else 0x0000. Registered.
- overflow  output  1  signed overflow of A − B. Registered.

## Operation
- Compute diff = A + ~B + 1 over 16 bits, using a ripple-carry chain with carry-in 1.
- ovf = (A[15] != B[15]) && (diff[15] != A[15]). This is equivalent to carry into bit 15 XOR carry out of bit 15.
- lt = diff[15] XOR ovf. This gives the correct signed comparison even when the subtraction overflows.
- The next value of out is {15'b0, lt}. Bits 15:1 of out are always 0.
- The next value of overflow is ovf.
- A == B gives lt = 0 and ovf = 0.
- There are no enables and no handshake. A new comparison is captured on every clock edge.

## Timing
- Latency is 1 cycle. A and B sampled at rising edge N appear on out and overflow after edge N.
- Throughput is one comparison per cycle.
- Reset:
  - rst_n low forces out = 0x0000 and overflow = 0 immediately, without waiting for clk.
  - Outputs stay at those values while rst_n is low.
  - The first capture happens on the first rising clk edge after rst_n goes high.
- Reset asserted mid-stream discards the pending comparison. No stale value is held afterward.
- The combinational path from A/B to the output flops is a 16-stage carry chain. It must close timing within one clk period.
- There is no combinational path from the inputs to the outputs.

## Structure
- Shared ALU package holds:
  - constant DATA_W = 16;
  - typedef word_t, a 16-bit logic vector;
  - constants SLT_TRUE = 16'h0001 and SLT_FALSE = 16'h0000.
- One sub-module, full_adder_1b, with inputs a, b, cin and outputs sum, cout.
  - Instantiate it 16 times via generate to form the subtractor, with ~B fed in and carry-in 1.
  - Expose the carries into and out of bit 15 for the overflow calculation.
- Top level contents: inversion of B, the adder chain, the lt/ovf logic and two output registers (out, overflow) with async active-low reset.

## Test plan
Each case applies the stimulus, waits one clk edge, then checks the outputs.
- Reset: rst_n = 0 with arbitrary A/B → out = 0x0000, overflow = 0 immediately, before any clk edge. Release reset, then A = 0, B = 0 → out = 0x0000, overflow = 0.
- A = 4, B = 2 → out = 0x0000, overflow = 0. With A = 2, B = 4 → out = 0x0001, overflow = 0.
- A = −4 (0xFFFC), B = −2 (0xFFFE) → out = 0x0001, overflow = 0. With A = −2, B = −4 → out = 0x0000, overflow = 0.
- A = B = 0x7FFF → out = 0x0000, overflow = 0. With A = B = 0x8000 → out = 0x0000, overflow = 0.
- Overflow cases:
  - A = 0x8000, B = 0x0001 → out = 0x0001, overflow = 1.
  - A = 0x7FFF, B = 0xFFFF → out = 0x0000, overflow = 1.
- Back-to-back streaming: a new A/B every cycle produces results delayed by exactly one cycle. Assert rst_n low mid-stream → outputs clear asynchronously, and the first post-reset result appears one edge after release.
